// File: rtl/memory_stage_if.sv
// Signal bundle of the memory stage: upstream pipeline inputs, data-memory bus and writeback outputs.
// The master modport is the stage itself; the slave modport is everything around it.
interface memory_stage_if;
    // Handshakes: dmem_req stays high, with dmem_we/addr/wdata/wstrb stable, up to and
    // including the cycle dmem_ack is high. mem_stall high means upstream keeps every mem_* input unchanged.
    logic        mem_v;
    logic [31:0] mem_ir;
    logic [63:0] mem_npc;
    logic [63:0] mem_alu_result;
    logic [63:0] mem_store_data;
    logic        mem_stall;

    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_err;

    logic        wb_v;
    logic [31:0] wb_ir;
    logic [63:0] wb_npc;
    logic [63:0] wb_alu_result;
    logic [63:0] wb_mem_result;
    logic        mem_lam;
    logic        mem_laf;
    logic        mem_sam;
    logic        mem_saf;

    logic [0:0]  fsm_state;

    modport master (
        input  mem_v, mem_ir, mem_npc, mem_alu_result, mem_store_data,
        input  dmem_rdata, dmem_ack, dmem_err,
        output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output wb_v, wb_ir, wb_npc, wb_alu_result, wb_mem_result,
        output mem_lam, mem_laf, mem_sam, mem_saf, fsm_state
    );

    modport slave (
        output mem_v, mem_ir, mem_npc, mem_alu_result, mem_store_data,
        output dmem_rdata, dmem_ack, dmem_err,
        input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  wb_v, wb_ir, wb_npc, wb_alu_result, wb_mem_result,
        input  mem_lam, mem_laf, mem_sam, mem_saf, fsm_state
    );
endinterface

// File: rtl/memory_stage.sv
// Memory stage of an RV64 pipeline: load/store issue, lane shifting, extension and fault flags.
// Optional feature: define MEM_TIMEOUT_EN to fault an access that waits TIMEOUT_CYCLES without an ack.
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    memory_stage_if.master bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT     = 1'b1;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // The wait counter is 8 bits wide, so only 1..255 is meaningful.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
    end

    logic [0:0]  state;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [2:0]  lane;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        do_access;
    logic        issue;
    logic        timeout;
    logic [7:0]  size_mask;
    logic [63:0] shifted;
    logic [63:0] load_data;

    logic        wb_v_q;
    logic [31:0] wb_ir_q;
    logic [63:0] wb_npc_q;
    logic [63:0] wb_alu_q;
    logic [63:0] wb_mem_q;
    logic        lam_q;
    logic        laf_q;
    logic        sam_q;
    logic        saf_q;

    assign opcode   = bus.mem_ir[6:0];
    assign funct3   = bus.mem_ir[14:12];
    assign lane     = bus.mem_alu_result[2:0];
    assign is_load  = bus.mem_v && (opcode == OP_LOAD) && (funct3 != 3'b111);
    assign is_store = bus.mem_v && (opcode == OP_STORE) && !funct3[2];

    // funct3[1:0] encodes the access size for both loads and stores.
    always_comb begin
        misaligned = 1'b0;
        size_mask  = 8'h01;
        case (funct3[1:0])
            2'd0: begin
                misaligned = 1'b0;
                size_mask  = 8'h01;
            end
            2'd1: begin
                misaligned = lane[0];
                size_mask  = 8'h03;
            end
            2'd2: begin
                misaligned = |lane[1:0];
                size_mask  = 8'h0F;
            end
            default: begin
                misaligned = |lane;
                size_mask  = 8'hFF;
            end
        endcase
    end

    assign do_access = (is_load || is_store) && !misaligned;
    assign issue     = (state == IDLE) && do_access;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_count;

    // An ack in the last permitted WAIT cycle still wins over the timeout.
    assign timeout = (state == WAIT) && !bus.dmem_ack && (wait_count == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_count <= '0;
        end else if ((state == WAIT) && !bus.dmem_ack && !timeout) begin
            wait_count <= wait_count + 8'd1;
        end else begin
            wait_count <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Gated by reset_n so reset silences the bus even while a memory op is presented.
    assign bus.mem_stall = reset_n && (issue || ((state == WAIT) && !bus.dmem_ack && !timeout));
    assign bus.dmem_req  = reset_n && (issue || ((state == WAIT) && !timeout));
    assign bus.dmem_we   = bus.dmem_req && is_store;
    assign bus.dmem_addr = {bus.mem_alu_result[63:3], 3'b000};

    always_comb begin
        bus.dmem_wstrb = 8'h00;
        bus.dmem_wdata = bus.mem_store_data << {lane, 3'b000};
        if (bus.dmem_req && is_store) begin
            bus.dmem_wstrb = size_mask << lane;
        end
    end

    always_comb begin
        shifted = bus.dmem_rdata >> {lane, 3'b000};
        case (funct3)
            3'd0:    load_data = {{56{shifted[7]}},  shifted[7:0]};
            3'd1:    load_data = {{48{shifted[15]}}, shifted[15:0]};
            3'd2:    load_data = {{32{shifted[31]}}, shifted[31:0]};
            3'd4:    load_data = {56'd0, shifted[7:0]};
            3'd5:    load_data = {48'd0, shifted[15:0]};
            3'd6:    load_data = {32'd0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wb_v_q   <= 1'b0;
            wb_ir_q  <= '0;
            wb_npc_q <= '0;
            wb_alu_q <= '0;
            wb_mem_q <= '0;
            lam_q    <= 1'b0;
            laf_q    <= 1'b0;
            sam_q    <= 1'b0;
            saf_q    <= 1'b0;
        end else begin
            wb_v_q <= 1'b0;
            lam_q  <= 1'b0;
            laf_q  <= 1'b0;
            sam_q  <= 1'b0;
            saf_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_access) begin
                        state <= WAIT;
                    end else begin
                        wb_v_q   <= bus.mem_v;
                        wb_ir_q  <= bus.mem_ir;
                        wb_npc_q <= bus.mem_npc;
                        wb_alu_q <= bus.mem_alu_result;
                        wb_mem_q <= '0;
                        lam_q    <= is_load && misaligned;
                        sam_q    <= is_store && misaligned;
                    end
                end
                default: begin
                    // Inputs are still held by upstream, so decode refers to the waiting op.
                    if (bus.dmem_ack || timeout) begin
                        state    <= IDLE;
                        wb_v_q   <= 1'b1;
                        wb_ir_q  <= bus.mem_ir;
                        wb_npc_q <= bus.mem_npc;
                        wb_alu_q <= bus.mem_alu_result;
                        wb_mem_q <= (is_load && bus.dmem_ack && !bus.dmem_err) ? load_data : '0;
                        laf_q    <= is_load && (timeout || bus.dmem_err);
                        saf_q    <= is_store && (timeout || bus.dmem_err);
                    end
                end
            endcase
        end
    end

    assign bus.wb_v          = wb_v_q;
    assign bus.wb_ir         = wb_ir_q;
    assign bus.wb_npc        = wb_npc_q;
    assign bus.wb_alu_result = wb_alu_q;
    assign bus.wb_mem_result = wb_mem_q;
    assign bus.mem_lam       = lam_q;
    assign bus.mem_laf       = laf_q;
    assign bus.mem_sam       = sam_q;
    assign bus.mem_saf       = saf_q;
    assign bus.fsm_state     = state;
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of WAIT cycles before an access fault (1..255).
REQ-002 CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 RESET_N  in  1  reset; asynchronous, active-low.
REQ-004 MEM_V  in  1  valid instruction present at stage input.
REQ-005 MEM_IR  in  32  instruction word; opcode [6:0], funct3 [14:12].
REQ-006 MEM_NPC  in  64  PC+4, passed through.
REQ-007 MEM_ALU_RESULT  in  64  effective address for loads and stores; otherwise ALU result, passed through.
REQ-008 MEM_STORE_DATA  in  64  rs2 value for stores.
REQ-009 DMEM_REQ  out  1  data-memory request, held until response.
REQ-010 DMEM_WE  out  1  1 = store, 0 = load.
REQ-011 DMEM_ADDR  out  64  doubleword-aligned address {addr[63:3],3'b0}.
REQ-012 DMEM_WDATA  out  64  lane-shifted store data.
REQ-013 DMEM_WSTRB  out  8  byte enables; zero for loads.
REQ-014 DMEM_RDATA  in  64  read doubleword, valid with DMEM_ACK.
REQ-015 DMEM_ACK  in  1  access complete.
REQ-016 DMEM_ERR  in  1  bus error, sampled with DMEM_ACK.
REQ-017 MEM_STALL  out  1  combinational; upstream SHALL hold all MEM_* inputs stable while high.
REQ-018 WB_V, WB_IR[31:0], WB_NPC[63:0], WB_ALU_RESULT[63:0]  out  registered pass-through to writeback.
REQ-019 WB_MEM_RESULT  out  64  extended load data.
REQ-020 MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF  out  1 each  load/store address-misaligned / access-fault flags.

Function
REQ-021 Load = opcode 0000011 (funct3 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU); store = opcode 0100011 (funct3 0..3); all other valid instructions SHALL be non-memory.
REQ-022 FSM states IDLE and WAIT; reset state IDLE.
REQ-023 Non-memory instruction or MEM_V=0 in IDLE: WB_* SHALL load on the next edge (one-cycle latency), MEM_STALL=0.
REQ-024 Aligned memory operation in IDLE: DMEM_REQ SHALL assert in the same cycle, MEM_STALL=1, next state WAIT.
REQ-025 In WAIT, DMEM_REQ and MEM_STALL SHALL stay high and WB_V SHALL be 0 until DMEM_ACK=1; on ACK, WB_* loads at that edge, MEM_STALL=0 in that cycle, next state IDLE.
REQ-026 Misaligned address (addr mod size != 0): no DMEM_REQ; MEM_LAM/MEM_SAM=1 with WB_V=1 for one cycle; one-cycle latency.
REQ-027 DMEM_ACK with DMEM_ERR=1 SHALL raise MEM_LAF/MEM_SAF instead of data; ERR has priority over data.
REQ-028 Fault flags SHALL be 1 only in the cycle WB_V=1 for the faulting instruction.
REQ-029 Loads: byte lane = addr[2:0]; the selected bytes SHALL be sign-extended (B/H/W) or zero-extended (BU/HU/WU) to 64 bits.
REQ-030 Stores: WDATA = data << (8*addr[2:0]); WSTRB = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
REQ-031 DMEM_ACK/DMEM_ERR in IDLE SHALL be ignored.

Reset
REQ-032 RESET_N low SHALL immediately force IDLE, DMEM_REQ=0, MEM_STALL=0 and all WB_* outputs and fault flags to 0, and clear the timeout counter.
REQ-033 Reset during WAIT SHALL abandon the access; an ACK arriving after release SHALL be ignored.

Configuration
REQ-034 MEM_TIMEOUT_EN defined: a counter SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES without ACK it SHALL raise MEM_LAF/MEM_SAF with WB_V=1, drop DMEM_REQ, and return to IDLE.
REQ-035 MEM_TIMEOUT_EN undefined: no counter logic; WAIT SHALL persist indefinitely and TIMEOUT_CYCLES is unused.

Verification
REQ-036 LB addr 0x1003, RDATA byte3=0x80 -> DMEM_ADDR 0x1000, WB_MEM_RESULT 0xFFFFFFFFFFFFFF80.
REQ-037 SH addr 0x1006, data 0xBEEF -> WSTRB 0xC0, WDATA[63:48]=0xBEEF, DMEM_WE=1.
REQ-038 LW addr 0x1002 -> no DMEM_REQ, MEM_LAM=1 and WB_V=1 for exactly one cycle.
REQ-039 SD with ACK+ERR after 3 wait cycles -> MEM_SAF=1, MEM_STALL high exactly 3 cycles plus the ACK cycle until deassert in the ACK cycle.
REQ-040 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ACK -> MEM_LAF=1 after 4 WAIT cycles, DMEM_REQ=0, state IDLE.
REQ-041 RESET_N low in WAIT, then ACK after release -> all outputs 0, no WB_V pulse.
